// File: rtl/fetch_stage.sv
// Instruction fetch stage with F/D pipeline register. Control flow resolves in D
// with one delay slot; stalls freeze PC and F/D, and reset overrides both.
module fetch_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [2:0]  d_branch_type,
  input  logic        d_equal,
  input  logic [15:0] d_imm16,
  input  logic [25:0] d_imm26,
  input  logic [31:0] d_rs_data,
  input  logic [31:0] f_instr,
  output logic [31:0] f_pc,
  output logic [31:0] d_instr,
  output logic [31:0] d_pc,
  output logic [31:0] d_pc8,
  output logic        d_valid
);

  typedef enum logic [2:0] {
    BR_NONE = 3'b000,
    BR_BEQ  = 3'b001,
    BR_BNE  = 3'b010,
    BR_J    = 3'b011,
    BR_JR   = 3'b100
  } br_e;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  logic [31:0] f_pc_q, f_pc_d;
  logic [31:0] d_instr_q, d_instr_d;
  logic [31:0] d_pc_q, d_pc_d;
  logic        d_valid_q, d_valid_d;

  br_e         br_eff;
  logic [31:0] d_pc_plus4;
  logic [31:0] br_target;
  logic [31:0] npc;

  // An empty F/D slot or a reserved encoding must never redirect fetch.
  always_comb begin
    br_eff = BR_NONE;
    if (d_valid_q && (d_branch_type <= 3'b100)) begin
      br_eff = br_e'(d_branch_type);
    end
  end

  assign d_pc_plus4 = d_pc_q + 32'd4;
  assign br_target  = d_pc_plus4 + {{14{d_imm16[15]}}, d_imm16, 2'b00};

  always_comb begin
    npc = f_pc_q + 32'd4;
    case (br_eff)
      BR_BEQ:  if (d_equal)  npc = br_target;
      BR_BNE:  if (!d_equal) npc = br_target;
      BR_J:    npc = {d_pc_plus4[31:28], d_imm26, 2'b00};
      BR_JR:   npc = d_rs_data;
      default: npc = f_pc_q + 32'd4;
    endcase
  end

  always_comb begin
    f_pc_d    = f_pc_q;
    d_instr_d = d_instr_q;
    d_pc_d    = d_pc_q;
    d_valid_d = d_valid_q;
    if (!stall) begin
      f_pc_d    = npc;
      d_instr_d = f_instr;
      d_pc_d    = f_pc_q;
      d_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      f_pc_q    <= RESET_PC;
      d_instr_q <= 32'h0;
      d_pc_q    <= 32'h0;
      d_valid_q <= 1'b0;
    end else begin
      f_pc_q    <= f_pc_d;
      d_instr_q <= d_instr_d;
      d_pc_q    <= d_pc_d;
      d_valid_q <= d_valid_d;
    end
  end

  assign f_pc    = f_pc_q;
  assign d_instr = d_instr_q;
  assign d_pc    = d_pc_q;
  assign d_valid = d_valid_q;
  assign d_pc8   = d_pc_q + 32'd8;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios with literal expectations, then random
// traffic compared every cycle against an architectural model of fetch and F/D.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic [2:0]  d_branch_type = 3'b000;
  logic        d_equal = 1'b0;
  logic [15:0] d_imm16 = 16'h0;
  logic [25:0] d_imm26 = 26'h0;
  logic [31:0] d_rs_data = 32'h0;
  logic [31:0] f_instr = 32'h0;
  logic [31:0] f_pc, d_instr, d_pc, d_pc8;
  logic        d_valid;

  fetch_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .d_branch_type(d_branch_type),
    .d_equal(d_equal), .d_imm16(d_imm16), .d_imm26(d_imm26), .d_rs_data(d_rs_data),
    .f_instr(f_instr), .f_pc(f_pc), .d_instr(d_instr), .d_pc(d_pc), .d_pc8(d_pc8),
    .d_valid(d_valid)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit chk_en  = 1'b0;

  // Architectural state of the model
  logic [31:0] m_fpc, m_dpc, m_dinstr;
  logic        m_dvalid;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      n_tests++;
      if (f_pc !== m_fpc || d_pc !== m_dpc || d_instr !== m_dinstr ||
          d_valid !== m_dvalid || d_pc8 !== (m_dpc + 32'd8)) begin
        n_fail++;
        $display("FAIL cycle%0d: dut f_pc=%08h d_pc=%08h d_instr=%08h d_valid=%0b d_pc8=%08h model f_pc=%08h d_pc=%08h d_instr=%08h d_valid=%0b d_pc8=%08h",
                 cyc, f_pc, d_pc, d_instr, d_valid, d_pc8,
                 m_fpc, m_dpc, m_dinstr, m_dvalid, m_dpc + 32'd8);
      end
    end
  end

  // Drive one cycle of inputs, advance the model by one edge, and leave time at edge+1.
  task automatic step(input logic rst, input logic st, input logic [2:0] bt, input logic eq,
                      input logic [15:0] i16, input logic [25:0] i26,
                      input logic [31:0] rs, input logic [31:0] ins);
    logic [31:0] seq, target, nxt;
    logic [31:0] sext;
    reset = rst; stall = st; d_branch_type = bt; d_equal = eq;
    d_imm16 = i16; d_imm26 = i26; d_rs_data = rs; f_instr = ins;
    seq  = m_fpc + 32'd4;
    sext = {{16{i16[15]}}, i16};
    nxt  = seq;
    if (m_dvalid) begin
      if (bt == 3'd1 && eq)       nxt = m_dpc + 32'd4 + sext * 32'd4;
      else if (bt == 3'd2 && !eq) nxt = m_dpc + 32'd4 + sext * 32'd4;
      else if (bt == 3'd3) begin
        target = m_dpc + 32'd4;
        nxt = (target & 32'hF000_0000) | ({6'b0, i26} * 32'd4);
      end
      else if (bt == 3'd4)        nxt = rs;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      m_fpc = 32'h3000; m_dpc = 32'h0; m_dinstr = 32'h0; m_dvalid = 1'b0;
    end else if (!st) begin
      m_dpc = m_fpc; m_dinstr = ins; m_dvalid = 1'b1; m_fpc = nxt;
    end
    chk_en = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 3'd0, 1'b0, 16'h0, 26'h0, 32'h0, 32'h0000_1000 + k);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 3'd0, 1'b0, 16'h0, 26'h0, 32'h0, 32'h0);
  endtask

  initial begin
    m_fpc = 32'h0; m_dpc = 32'h0; m_dinstr = 32'h0; m_dvalid = 1'b0;

    // Reset state and sequential fetch
    do_reset();
    chk("reset_f_pc", f_pc, 32'h3000);
    chk("reset_d_valid", {31'b0, d_valid}, 32'h0);
    chk("reset_d_pc", d_pc, 32'h0);
    chk("reset_d_instr", d_instr, 32'h0);
    step(1'b0, 1'b0, 3'd0, 1'b0, 16'h0, 26'h0, 32'h0, 32'hA5A5_0001);
    chk("seq1_f_pc", f_pc, 32'h3004);
    chk("seq1_d_pc", d_pc, 32'h3000);
    chk("seq1_d_valid", {31'b0, d_valid}, 32'h1);
    chk("seq1_d_instr", d_instr, 32'hA5A5_0001);
    idle(2);
    chk("seq3_f_pc", f_pc, 32'h300C);
    chk("seq3_d_pc", d_pc, 32'h3008);

    // Taken beq: delay slot enters D
    do_reset(); idle(2);
    step(1'b0, 1'b0, 3'd1, 1'b1, 16'h0003, 26'h0, 32'h0, 32'h0);
    chk("beq_taken_f_pc", f_pc, 32'h3014);
    chk("beq_delay_d_pc", d_pc, 32'h3008);

    // Backward bne, then not-taken beq
    do_reset(); idle(5);
    step(1'b0, 1'b0, 3'd2, 1'b0, 16'hFFFE, 26'h0, 32'h0, 32'h0);
    chk("bne_back_f_pc", f_pc, 32'h300C);
    do_reset(); idle(5);
    step(1'b0, 1'b0, 3'd1, 1'b0, 16'hFFFE, 26'h0, 32'h0, 32'h0);
    chk("beq_not_taken_f_pc", f_pc, 32'h3018);

    // j then jr
    do_reset(); idle(1);
    step(1'b0, 1'b0, 3'd3, 1'b0, 16'h0, 26'h0000C40, 32'h0, 32'h0);
    chk("j_f_pc", f_pc, 32'h3100);
    step(1'b0, 1'b0, 3'd4, 1'b0, 16'h0, 26'h0, 32'h0000_3ABC, 32'h0);
    chk("jr_f_pc", f_pc, 32'h3ABC);

    // jal link value
    do_reset(); idle(9);
    d_branch_type = 3'd3;
    #1;
    chk("jal_d_pc", d_pc, 32'h3020);
    chk("jal_d_pc8", d_pc8, 32'h3028);

    // Stall holds a pending beq, then it resolves with the fresh d_equal
    do_reset(); idle(2);
    for (int k = 0; k < 2; k++) begin
      step(1'b0, 1'b1, 3'd1, 1'b0, 16'h0003, 26'h0, 32'h0, 32'hDEAD_0000 + k);
      chk("stall_f_pc", f_pc, 32'h3008);
      chk("stall_d_pc", d_pc, 32'h3004);
    end
    step(1'b0, 1'b0, 3'd1, 1'b1, 16'h0003, 26'h0, 32'h0, 32'h0);
    chk("post_stall_f_pc", f_pc, 32'h3014);

    // Reset priority over stall and taken jr; PC wrap
    do_reset(); idle(2);
    step(1'b1, 1'b1, 3'd4, 1'b0, 16'h0, 26'h0, 32'h0000_1234, 32'h0);
    chk("rst_prio_f_pc", f_pc, 32'h3000);
    chk("rst_prio_d_valid", {31'b0, d_valid}, 32'h0);
    idle(1);
    step(1'b0, 1'b0, 3'd4, 1'b0, 16'h0, 26'h0, 32'hFFFF_FFFC, 32'h0);
    chk("wrap_pre_f_pc", f_pc, 32'hFFFF_FFFC);
    idle(1);
    chk("wrap_f_pc", f_pc, 32'h0000_0000);

    // Random traffic against the model
    for (int k = 0; k < 3000; k++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) == 0),
           3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
           16'($urandom), 26'($urandom), $urandom, $urandom);
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset, with ports named as follows.
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
REQ-002 The module SHALL provide the following stall and branch-control inputs.
- stall  in  1  hazard stall request; holds PC and F/D register.
- d_branch_type  in  3  D-stage control-flow class: 000 none, 001 beq, 010 bne, 011 j/jal, 100 jr; 101-111 reserved.
- d_equal  in  1  D-stage comparator result (rs operand == rt operand, after forwarding).
- d_imm16  in  16  D-stage branch offset field.
- d_imm26  in  26  D-stage jump index field.
- d_rs_data  in  32  forwarded rs value, used as the jr target.
REQ-003 The module SHALL provide the following instruction-memory ports.
- f_instr  in  32  instruction word from IM at f_pc.
- f_pc  out  32  current fetch PC, driven to IM.
REQ-004 The module SHALL provide the following D-stage outputs.
- d_instr  out  32  F/D register instruction.
- d_pc  out  32  F/D register PC.
- d_pc8  out  32  d_pc + 8, the link value for jal.
- d_valid  out  1  F/D register holds a fetched instruction.

Function
REQ-005 f_pc SHALL be a 32-bit register; d_instr, d_pc and d_valid SHALL be registers; d_pc8 SHALL be combinational from d_pc.
REQ-006 When stall=0 at a rising edge, the following SHALL load together: f_pc<=npc, d_instr<=f_instr, d_pc<=f_pc, d_valid<=1.
REQ-007 When stall=1 at a rising edge, f_pc, d_instr, d_pc and d_valid SHALL all hold, and the branch decision SHALL be discarded.
REQ-008 The effective branch type SHALL be "none" when d_valid=0 or when d_branch_type is reserved (101-111).
REQ-009 npc SHALL be selected as follows:
- beq with d_equal=1: d_pc+4+(sign_extend(d_imm16)<<2).
- bne with d_equal=0: d_pc+4+(sign_extend(d_imm16)<<2).
- j/jal: {d_pc_plus4[31:28], d_imm26, 2'b00}.
- jr: d_rs_data, unmodified (low bits not masked).
- otherwise, including beq/bne not taken: f_pc+4.
REQ-010 All address additions SHALL be 32-bit modulo 2^32; f_pc=0xFFFFFFFC with no branch SHALL wrap to 0x00000000.
REQ-011 Branch resolution SHALL occur in D with one architectural delay slot. The instruction in F when a branch is in D SHALL always enter D on the next non-stalled edge; no flush SHALL exist.
REQ-012 Branch-to-fetch latency: a taken branch in D at edge N (stall=0) SHALL produce f_pc = target after edge N.
REQ-013 A stall cycle SHALL NOT consume the branch; the same D instruction SHALL re-evaluate npc with the d_equal/d_rs_data present on the first non-stalled edge.
REQ-014 d_pc8 SHALL be d_pc+8 modulo 2^32 in every cycle, independent of d_valid.

Reset
REQ-015 On a rising edge with reset=1, the following SHALL load: f_pc<=0x00003000, d_instr<=0x00000000, d_pc<=0x00000000, d_valid<=0.
REQ-016 reset SHALL take priority over stall and over any branch condition.
REQ-017 Reset asserted mid-stall or mid-branch SHALL leave no residual state; the first post-reset fetch address SHALL be 0x00003000.

Verification
REQ-018 Sequential fetch: reset, then 3 edges with stall=0 and no branches -> f_pc 0x3000, 0x3004, 0x3008, 0x300C; d_pc lags f_pc by one edge; d_valid=1 from the first post-reset edge.
REQ-019 Taken beq with delay slot: d_pc=0x3004, beq, d_equal=1, d_imm16=0x0003 -> after the edge, f_pc=0x3014 and d_pc=0x3008 (delay slot in D).
REQ-020 Backward bne and not-taken beq, in two cases:
- d_pc=0x3010, bne, d_equal=0, d_imm16=0xFFFE -> f_pc=0x300C.
- Same setup with beq, d_equal=0 -> f_pc = prior f_pc+4.
REQ-021 Jumps, in three cases:
- j: d_pc=0x3000, d_imm26=0x0000C40 -> f_pc=0x00003100.
- jr: d_rs_data=0x00003ABC -> f_pc=0x00003ABC.
- jal: d_pc=0x3020 -> d_pc8=0x3028.
REQ-022 Stall then branch: beq in D, stall=1 for 2 edges with d_equal=0 -> all registers hold. The third edge has stall=0 and d_equal=1 -> the branch is taken.
REQ-023 Reset priority and wrap, in two cases:
- reset=1 together with stall=1 and a taken jr -> f_pc=0x3000, d_valid=0.
- f_pc=0xFFFFFFFC, no branch -> f_pc=0x00000000.
